// File: rtl/desc_sample_addr_gen.sv
// Descriptor sample address generator.
// Walks sample offsets per keypoint, emits clamped coords.
module desc_sample_addr_gen #(
  parameter int NUM_SAMPLES = 32,
  parameter int IDX_W       = 5,
  parameter int COORD_W     = 10,
  parameter int OFF_W       = 5,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kp_valid,
  output logic               kp_ready,
  input  logic [COORD_W-1:0] kp_x,
  input  logic [COORD_W-1:0] kp_y,
  input  logic [7:0]         kp_ori,
  output logic [7:0]         rom_addr,
  output logic [IDX_W-1:0]   smp_idx,
  input  logic [OFF_W-1:0]   off_x,
  input  logic [OFF_W-1:0]   off_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_inb,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);

  localparam int SW = COORD_W + 2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SAMPLES - 1);
  localparam logic signed [SW-1:0] XLIM = SW'(IMG_W);
  localparam logic signed [SW-1:0] YLIM = SW'(IMG_H);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [COORD_W-1:0] kx, ky;
  logic accept, load, done;
  logic signed [SW-1:0] sx, sy;
  logic x_lo, x_hi, y_lo, y_hi;
  logic [COORD_W-1:0] cx, cy;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and handshake control
  always_comb begin
    state_nx = state;
    kp_ready = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        kp_ready = 1'b1;
        if (kp_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        load = !out_valid || out_ready;
        if (load && smp_idx == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // offset add, bounds test and clamp for the current sample
  always_comb begin
    sx = $signed({2'b00, kx})
       + $signed({{(SW-OFF_W){off_x[OFF_W-1]}}, off_x});
    sy = $signed({2'b00, ky})
       + $signed({{(SW-OFF_W){off_y[OFF_W-1]}}, off_y});
    x_lo = sx[SW-1];
    y_lo = sy[SW-1];
    x_hi = sx >= XLIM;
    y_hi = sy >= YLIM;
    cx = x_lo ? '0 : (x_hi ? XMAX : sx[COORD_W-1:0]);
    cy = y_lo ? '0 : (y_hi ? YMAX : sy[COORD_W-1:0]);
  end

  assign busy = (state != IDLE);

  // keypoint latch, sample counter and output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      kx        <= '0;
      ky        <= '0;
      rom_addr  <= '0;
      smp_idx   <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_inb   <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        kx       <= kp_x;
        ky       <= kp_y;
        rom_addr <= kp_ori;
        smp_idx  <= '0;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_x     <= cx;
        out_y     <= cy;
        out_inb   <= !(x_lo || x_hi || y_lo || y_hi);
        out_idx   <= smp_idx;
        out_last  <= (smp_idx == LAST);
        if (smp_idx != LAST) smp_idx <= smp_idx + 1'b1;
      end
      if (done) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/desc_sample_addr_gen.md
Name: desc_sample_addr_gen

Overview:
Descriptor sample address generator, one stage downstream of the per-sample direction offset ROM bank.
- For each accepted keypoint (x, y, orientation code), steps through NUM_SAMPLES sample indices.
- Drives the ROM bank with the orientation address and the sample index, then consumes the returned signed dx/dy offsets.
- Emits rotated absolute sample coordinates with an in-bounds flag over a valid/ready stream to the gradient fetch stage.

Parameters:
NUM_SAMPLES, 32, samples per keypoint; ROM bank select range 0..NUM_SAMPLES-1
IDX_W, 5, width of sample index (clog2 NUM_SAMPLES)
COORD_W, 10, unsigned coordinate width
OFF_W, 5, signed two's-complement offset width from ROM bank
IMG_W, 640, image width in pixels
IMG_H, 480, image height in pixels

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
kp_valid  in  1  keypoint present
kp_ready  out  1  block can accept keypoint
kp_x  in  COORD_W  keypoint column
kp_y  in  COORD_W  keypoint row
kp_ori  in  8  orientation code (ROM address)
rom_addr  out  8  address to offset ROM bank
smp_idx  out  IDX_W  ROM bank select (current sample)
off_x  in  OFF_W  signed column offset, combinational ROM return
off_y  in  OFF_W  signed row offset, combinational ROM return
out_valid  out  1  sample coordinate valid
out_ready  in  1  downstream accepts sample
out_x  out  COORD_W  sample column, clamped
out_y  out  COORD_W  sample row, clamped
out_inb  out  1  1 = unclamped position inside image
out_idx  out  IDX_W  sample index of this output
out_last  out  1  final sample of keypoint
busy  out  1  state != IDLE

Behaviour:
- Clock/reset: single clock clk; rst synchronous active-high, sampled on rising edge.
- Reset values: state=IDLE; out_valid, out_x, out_y, out_inb, out_idx, out_last, rom_addr, smp_idx all 0. After reset, kp_ready=1 and busy=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: kp_ready=1. On kp_valid&kp_ready, latch kp_x/kp_y, set rom_addr=kp_ori, smp_idx=0, go to RUN.
  - RUN: kp_ready=0. Load condition is out_valid==0 or out_ready==1. When it holds, register the result for the current smp_idx into the output slot and set out_valid=1.
    - If smp_idx < NUM_SAMPLES-1: smp_idx increments.
    - Else: set out_last=1 and go to DRAIN.
    - If the load condition is false, smp_idx holds.
  - DRAIN: on out_valid&out_ready, clear out_valid and out_last, return to IDLE. A new keypoint is accepted the cycle after IDLE is re-entered, not in DRAIN.
- Latency: kp accepted on cycle N; first out_valid on cycle N+2. Without backpressure, one sample per cycle, NUM_SAMPLES consecutive beats.
- rom_addr is constant for the whole keypoint. off_x/off_y are consumed combinationally in the same cycle smp_idx is presented; the ROM bank is purely combinational.
- Arithmetic:
  - sx = zero-extend(kp_x, COORD_W+2) + sign-extend(off_x, COORD_W+2); sy likewise with kp_y and off_y.
  - out_inb = (sx>=0) & (sx<IMG_W) & (sy>=0) & (sy<IMG_H).
  - Clamping: out_x = 0 if sx<0, IMG_W-1 if sx>=IMG_W, else sx[COORD_W-1:0]. out_y is clamped the same way against IMG_H.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold unchanged.
- Input handshake: kp_valid while busy is ignored (kp_ready=0), and kp_* are not sampled.
- Reset mid-operation: rst in any state discards the keypoint and any pending output and returns to reset values on the next edge. No partial beat is emitted afterwards.
- out_ready asserted with out_valid=0 has no effect.

Test Plan:
Use a stub ROM returning off_x = off_y = 8 - ori[7:4] (signed 5-bit, 0x19 = -7) for all indices.
- Reset, kp (100,50) ori 0x00, out_ready=1 -> out_valid at cycle N+2. 32 beats of (108,58), out_inb=1, out_idx 0..31, out_last only on idx 31. Then busy=0, kp_ready=1.
- kp (100,50) ori 0x95 (off -1) -> all beats (99,49), out_inb=1. rom_addr=0x95 throughout.
- kp (3,475) ori 0xF0 (off -7): sx=-4 -> out_x=0, out_inb=0. kp (636,2) ori 0x00: sx=644 -> out_x=639, out_y=10, out_inb=0.
- Backpressure: out_ready low for 5 cycles at idx 7 -> out_x/out_y/out_idx=7 held, smp_idx held. Resume gives idx 8 with no drops or duplicates; total 32 beats.
- kp_valid held high continuously -> second keypoint accepted exactly one cycle after the first's last beat handshakes. kp_* changes during RUN do not affect outputs.
- Assert rst at idx 12 mid-run -> next cycle out_valid=0, busy=0, kp_ready=1. A new keypoint afterwards restarts at out_idx 0.
